// File: rtl/instr_encoder.sv
// Turns field requests into RV32I words and streams them with ascending addresses.
// Latency: 1 cycle from accepted request to out_valid; sustains 1 word per cycle.
// Backpressure: in_ready drops while a word is stalled, on illegal input (sticky) or when full.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_class,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [20:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        full,
  output logic        err,
  input  logic        clear
);

  // Word counter never wraps, so it must hold MAX_WORDS itself; keep at least 7 bits.
  localparam int CW = ($clog2(MAX_WORDS + 1) > 7) ? $clog2(MAX_WORDS + 1) : 7;

  typedef enum logic [1:0] {S_RUN, S_ERROR, S_FULL} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [31:0]     enc_word;
  logic            illegal;
  logic            accept;
  logic            last_word;

  // clear wins over a same-cycle request, so it masks acceptance here.
  assign accept    = in_valid && in_ready && !clear;
  assign last_word = (count == CW'(MAX_WORDS - 1));

  // Field packing per instruction class; branch/jump targets must be halfword aligned.
  always_comb begin
    enc_word = '0;
    illegal  = 1'b0;
    case (in_class)
      3'd0: enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      3'd1: enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      3'd2: enc_word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, 7'b0110011};
      3'd3: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        illegal  = imm[0];
      end
      3'd4: begin
        if (funct3 == 3'b001 || funct3 == 3'b101)
          enc_word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, 7'b0010011};
        else
          enc_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        illegal  = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  // Mode register: RUN / ERROR / FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nxt;
  end

  // Mode transitions; only clear leaves ERROR or FULL.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_RUN;
    end else if (state == S_RUN && accept) begin
      if (illegal)        state_nxt = S_ERROR;
      else if (last_word) state_nxt = S_FULL;
    end
  end

  // Mode-derived outputs; a stalled word blocks intake so it is never overwritten.
  always_comb begin
    full     = (state == S_FULL);
    err      = (state == S_ERROR);
    in_ready = (state == S_RUN) && (!out_valid || out_ready);
  end

  // Output word register and word counter; illegal requests are consumed without a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      count      <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      count     <= '0;
    end else if (accept && !illegal) begin
      out_valid  <= 1'b1;
      imem_addr  <= BASE_ADDR + (32'(count) << 2);
      imem_wdata <= enc_word;
      count      <= count + CW'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a transaction-level reference model.
// Model advances on each clock edge; outputs are compared on every falling edge.
// Retired words are logged with their cycle number for address/order/bubble checks.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_class = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [20:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] imem_addr, imem_wdata;
  logic        full, err;
  logic        clear = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  // Reference model state
  logic        m_ov = 1'b0, m_full = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = BASE, m_data = '0;
  int          m_cnt = 0;

  instr_encoder #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7b5(funct7b5), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .full(full), .err(err),
    .clear(clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  // Encoding built from field values with shifts, straight from the ISA layouts.
  function automatic logic [31:0] model_enc(input int c, input logic [4:0] d, input logic [4:0] s1,
                                            input logic [4:0] s2, input logic [2:0] f3,
                                            input logic f7, input logic [20:0] im);
    logic [31:0] b, r, d32, a32, b32, f32, s7;
    b   = {{11{im[20]}}, im};
    d32 = 32'(d) << 7;
    a32 = 32'(s1) << 15;
    b32 = 32'(s2) << 20;
    f32 = 32'(f3) << 12;
    s7  = 32'(f7) << 30;
    r   = '0;
    case (c)
      0: r = ((b & 32'hFFF) << 20) | a32 | (32'd2 << 12) | d32 | 32'h03;
      1: r = (((b >> 5) & 32'h7F) << 25) | b32 | a32 | (32'd2 << 12) | ((b & 32'h1F) << 7) | 32'h23;
      2: r = s7 | b32 | a32 | f32 | d32 | 32'h33;
      3: r = (((b >> 12) & 1) << 31) | (((b >> 5) & 32'h3F) << 25) | b32 | a32
             | (((b >> 1) & 32'hF) << 8) | (((b >> 11) & 1) << 7) | 32'h63;
      4: begin
        if (f3 == 3'd1 || f3 == 3'd5) r = s7 | ((b & 32'h1F) << 20);
        else                          r = (b & 32'hFFF) << 20;
        r = r | a32 | f32 | d32 | 32'h13;
      end
      5: r = (((b >> 20) & 1) << 31) | (((b >> 1) & 32'h3FF) << 21) | (((b >> 11) & 1) << 20)
             | (((b >> 12) & 32'hFF) << 12) | d32 | 32'h6F;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic bit model_illegal(input int c, input logic [20:0] im);
    return (c > 5) || ((c == 3 || c == 5) && im[0]);
  endfunction

  // Reference model: one transaction step per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov <= 1'b0; m_cnt <= 0; m_full <= 1'b0; m_err <= 1'b0;
      m_addr <= BASE; m_data <= '0;
    end else if (clear) begin
      m_ov <= 1'b0; m_cnt <= 0; m_full <= 1'b0; m_err <= 1'b0;
    end else begin
      if (m_ov && out_ready) m_ov <= 1'b0;
      if (in_valid && !m_full && !m_err && (!m_ov || out_ready)) begin
        if (model_illegal(int'(in_class), imm)) begin
          m_err <= 1'b1;
        end else begin
          m_ov   <= 1'b1;
          m_addr <= BASE + 32'(4 * m_cnt);
          m_data <= model_enc(int'(in_class), rd, rs1, rs2, funct3, funct7b5, imm);
          m_cnt  <= m_cnt + 1;
          if (m_cnt + 1 == MAXW) m_full <= 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, and log words that will retire.
  always @(negedge clk) begin
    chk("cmp_out_valid", 32'(out_valid), 32'(m_ov));
    chk("cmp_in_ready", 32'(in_ready), 32'(!m_full && !m_err && (!m_ov || out_ready)));
    chk("cmp_full", 32'(full), 32'(m_full));
    chk("cmp_err", 32'(err), 32'(m_err));
    if (m_ov || !rst_n) begin
      chk("cmp_addr", imem_addr, m_addr);
      chk("cmp_wdata", imem_wdata, m_data);
    end
    if (rst_n && out_valid && out_ready && !clear) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
      log_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic send(input logic [2:0] c, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                      input logic [20:0] im);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    in_class = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7b5 = f7; imm = im;
    in_valid = 1'b1;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      tick(1);
      n++;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic pop_word(input string name, input logic [31:0] ea, input logic [31:0] ed,
                          output int c);
    c = -1;
    chk({name, "_present"}, 32'(log_addr.size() > 0), 32'd1);
    if (log_addr.size() > 0) begin
      chk({name, "_addr"}, log_addr.pop_front(), ea);
      chk({name, "_data"}, log_data.pop_front(), ed);
      c = log_cyc.pop_front();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, c1;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick(2);
    #1 rst_n = 1'b1;
    tick(1);

    // lw x6, -4(x9): visible one cycle after acceptance at the base address
    send(3'd0, 5'd6, 5'd9, 5'd0, 3'd0, 1'b0, -21'sd4);
    @(negedge clk);
    chk("lw_latency_valid", 32'(out_valid), 32'd1);
    chk("lw_wdata", imem_wdata, 32'hFFC4_A303);
    chk("lw_addr", imem_addr, BASE);
    tick(2);
    pop_word("lw_log", BASE, 32'hFFC4_A303, c0);
    pulse_clear();

    // sw then add back to back, no bubble between them
    send(3'd1, 5'd6, 5'd9, 5'd6, 3'd0, 1'b0, 21'd8);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0);
    tick(3);
    pop_word("sw", BASE, 32'h0064_A423, c0);
    pop_word("add", BASE + 4, 32'h0020_81B3, c1);
    chk("no_bubble", 32'(c1 - c0), 32'd1);

    // jal x0, 8 stalled for three cycles
    out_ready = 1'b0;
    send(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'd8);
    repeat (3) begin
      @(negedge clk);
      chk("jal_hold_valid", 32'(out_valid), 32'd1);
      chk("jal_hold_wdata", imem_wdata, 32'h0080_006F);
      chk("jal_hold_rdy", 32'(in_ready), 32'd0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(2);
    pop_word("jal", BASE + 8, 32'h0080_006F, c0);

    // misaligned beq: no word, sticky error until clear
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd3);
    @(negedge clk);
    chk("beq_err", 32'(err), 32'd1);
    chk("beq_rdy", 32'(in_ready), 32'd0);
    tick(2);
    chk("beq_no_word", 32'(log_addr.size()), 32'd0);
    pulse_clear();
    @(negedge clk);
    chk("clear_err", 32'(err), 32'd0);
    tick(1);
    send(3'd0, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 21'd0);
    tick(2);
    pop_word("after_clear", BASE, 32'h0001_2083, c0);

    // illegal class, then clear colliding with a request
    send(3'd6, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 21'd0);
    @(negedge clk);
    chk("class6_err", 32'(err), 32'd1);
    tick(1);
    in_class = 3'd4; rd = 5'd7; rs1 = 5'd7; funct3 = 3'd0; imm = 21'd1;
    in_valid = 1'b1;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_prio_valid", 32'(out_valid), 32'd0);
    tick(1);

    // fill to MAX_WORDS with mixed classes; fifth request must stall
    send(3'd4, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, -21'sd1);
    send(3'd4, 5'd5, 5'd6, 5'd0, 3'd5, 1'b1, 21'd3);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -21'sd8);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0);
    @(negedge clk);
    chk("full_set", 32'(full), 32'd1);
    tick(1);
    in_class = 3'd0; rd = 5'd1; rs1 = 5'd1; imm = 21'd0;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("fifth_stall_rdy", 32'(in_ready), 32'd0);
      chk("fifth_stall_full", 32'(full), 32'd1);
      tick(1);
    end
    in_valid = 1'b0;
    chk("fill_count", 32'(log_addr.size()), 32'd4);
    pop_word("addi", BASE, 32'hFFF1_0093, c0);
    pop_word("srai", BASE + 4, 32'h4033_5293, c0);
    pop_word("beq", BASE + 8, 32'hFE20_8CE3, c0);
    pop_word("sub", BASE + 12, 32'h4020_81B3, c0);

    // asynchronous reset while a word is stalled
    pulse_clear();
    out_ready = 1'b0;
    send(3'd0, 5'd6, 5'd9, 5'd0, 3'd0, 1'b0, -21'sd4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", imem_addr, BASE);
    chk("arst_wdata", imem_wdata, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick(1);
    send(3'd4, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, -21'sd1);
    tick(2);
    pop_word("post_rst", BASE, 32'hFFF1_0093, c0);
    chk("log_drained", 32'(log_addr.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
